countdown_timer: RTL and testbench

Sequential countdown timer for the 50 MHz board clock, complementing the existing up-counting hundredth-second divider. It contains its own 19-bit down-counting prescaler, which produces a 1/100 s tick. It also holds a 4-digit BCD register (SS.hh, 00.00–59.99) that decrements once per tick. The block feeds the seven-segment display path and raises a one-cycle `done` pulse when the count reaches 00.00.

---
 rtl/countdown_timer.sv | 128 ++++++++++++
 tb/tb_countdown_timer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// countdown_timer
// ---------------
// SS.hh countdown timer (00.00 - 59.99) for the 50 MHz board clock. An
// internal 19-bit down-counting prescaler produces a 1/100 s tick. Each
// tick decrements a 4-digit BCD register by one hundredth. A one-cycle
// done pulse is raised when the count reaches 00.00.
//
// Parameters
//   DIV_TERM  prescaler reload value; the tick period is DIV_TERM+1 cycles
//
// Ports
//   clk      in   1   system clock, rising edge
//   rst      in   1   synchronous active-high reset
//   load     in   1   load sanitized preset and stop the timer
//   preset   in   16  BCD {sec_tens, sec_ones, hun_tens, hun_ones}
//   start    in   1   begin or resume counting (ignored at 00.00)
//   stop     in   1   pause counting; the partial prescaler period is kept
//   digits   out  16  current BCD value, same packing as preset
//   running  out  1   high while counting
//   tick     out  1   high in the first cycle a decremented value is visible
//   done     out  1   one-cycle pulse when the count reaches 00.00
module countdown_timer #(
    parameter logic [18:0] DIV_TERM = 19'h7A11F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] preset,
    input  logic        start,
    input  logic        stop,
    output logic [15:0] digits,
    output logic        running,
    output logic        tick,
    output logic        done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_reg;
    logic [18:0] presc_reg;
    logic [15:0] digits_reg;
    logic        tick_reg;
    logic        done_reg;

    // Clamp each digit to its legal range: sec_tens to 5, the rest to 9.
    function automatic logic [15:0] sanitize(input logic [15:0] p);
        logic [3:0] st, so, ht, ho;
        st = (p[15:12] > 4'd5) ? 4'd5 : p[15:12];
        so = (p[11:8]  > 4'd9) ? 4'd9 : p[11:8];
        ht = (p[7:4]   > 4'd9) ? 4'd9 : p[7:4];
        ho = (p[3:0]   > 4'd9) ? 4'd9 : p[3:0];
        return {st, so, ht, ho};
    endfunction

    // Subtract one hundredth with BCD borrow. sec_tens only decrements when
    // borrowed into; it never wraps because a tick at 00.00 cannot happen.
    function automatic logic [15:0] bcd_dec(input logic [15:0] d);
        logic [3:0] st, so, ht, ho;
        logic       borrow;
        st = d[15:12];
        so = d[11:8];
        ht = d[7:4];
        ho = d[3:0];
        borrow = (ho == 4'd0);
        ho = borrow ? 4'd9 : ho - 4'd1;
        if (borrow) begin
            borrow = (ht == 4'd0);
            ht = borrow ? 4'd9 : ht - 4'd1;
        end
        if (borrow) begin
            borrow = (so == 4'd0);
            so = borrow ? 4'd9 : so - 4'd1;
        end
        if (borrow && st != 4'd0) begin
            st = st - 4'd1;
        end
        return {st, so, ht, ho};
    endfunction

    // Command priority: rst > load > stop > start. tick/done are pulses and
    // default low every cycle; only a RUN-state prescaler rollover sets them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            presc_reg  <= DIV_TERM;
            digits_reg <= 16'h0000;
            tick_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            tick_reg <= 1'b0;
            done_reg <= 1'b0;
            if (load) begin
                digits_reg <= sanitize(preset);
                presc_reg  <= DIV_TERM;
                state_reg  <= IDLE;
            end else if (stop) begin
                // Prescaler intentionally holds so resume keeps the partial period.
                state_reg <= IDLE;
            end else if (state_reg == IDLE) begin
                // No prescaler reload on start: a paused period resumes as-is.
                if (start && digits_reg != 16'h0000) begin
                    state_reg <= RUN;
                end
            end else begin
                if (presc_reg != 19'd0) begin
                    presc_reg <= presc_reg - 19'd1;
                end else begin
                    presc_reg  <= DIV_TERM;
                    tick_reg   <= 1'b1;
                    digits_reg <= bcd_dec(digits_reg);
                    if (digits_reg == 16'h0001) begin
                        state_reg <= IDLE;
                        done_reg  <= 1'b1;
                    end
                end
            end
        end
    end

    assign digits  = digits_reg;
    assign running = (state_reg == RUN);
    assign tick    = tick_reg;
    assign done    = done_reg;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer. Two instances share stimulus: one with
// DIV_TERM=3 (countdown, borrow chain, edge cases) and one with DIV_TERM=9
// (pause/resume). Outputs are sampled 1 ns after each rising edge.
module tb_countdown_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [15:0] preset = 16'h0000;
    logic        start = 1'b0;
    logic        stop = 1'b0;

    logic [15:0] digits3, digits9;
    logic        running3, running9;
    logic        tick3, tick9;
    logic        done3, done9;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    countdown_timer #(.DIV_TERM(19'd3)) dut3 (
        .clk(clk), .rst(rst), .load(load), .preset(preset),
        .start(start), .stop(stop),
        .digits(digits3), .running(running3), .tick(tick3), .done(done3)
    );

    countdown_timer #(.DIV_TERM(19'd9)) dut9 (
        .clk(clk), .rst(rst), .load(load), .preset(preset),
        .start(start), .stop(stop),
        .digits(digits9), .running(running9), .tick(tick9), .done(done9)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges; afterwards outputs reflect the last edge.
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
        end
        #1;
    endtask

    task automatic do_load(input logic [15:0] p);
        preset = p;
        load   = 1'b1;
        cyc(1);
        load   = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    // Integer centiseconds to packed BCD, computed arithmetically.
    function automatic logic [15:0] cs_to_bcd(input int cs);
        logic [3:0] a, b, c, d;
        a = 4'((cs / 1000) % 10);
        b = 4'((cs / 100) % 10);
        c = 4'((cs / 10) % 10);
        d = 4'(cs % 10);
        return {a, b, c, d};
    endfunction

    initial begin
        int ticks;
        int dones;
        int cs;

        // Reset
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1);
        check_eq("rst_digits", 32'(digits3), 32'h0000);
        check_eq("rst_running", 32'(running3), 32'd0);
        check_eq("rst_tick", 32'(tick3), 32'd0);
        check_eq("rst_done", 32'(done3), 32'd0);
        $display("txn reset: digits=%04h running=%0b", digits3, running3);

        // Basic countdown 00.03, tick every 4 cycles
        do_load(16'h0003);
        check_eq("basic_load", 32'(digits3), 32'h0003);
        check_eq("basic_idle", 32'(running3), 32'd0);
        do_start();
        check_eq("basic_running", 32'(running3), 32'd1);
        for (int k = 2; k >= 0; k--) begin
            cyc(3);
            check_eq("basic_no_tick", 32'(tick3), 32'd0);
            cyc(1);
            check_eq("basic_tick", 32'(tick3), 32'd1);
            check_eq("basic_digits", 32'(digits3), 32'(k));
            check_eq("basic_done", 32'(done3), (k == 0) ? 32'd1 : 32'd0);
            check_eq("basic_run", 32'(running3), (k == 0) ? 32'd0 : 32'd1);
            $display("txn basic tick: digits=%04h done=%0b", digits3, done3);
        end
        cyc(1);
        check_eq("basic_done_1cyc", 32'(done3), 32'd0);
        check_eq("basic_tick_1cyc", 32'(tick3), 32'd0);

        // Borrow chain from 10.00
        do_load(16'h1000);
        do_start();
        cyc(4);
        check_eq("borrow_tick", 32'(tick3), 32'd1);
        check_eq("borrow_0999", 32'(digits3), 32'h0999);
        $display("txn borrow first tick: digits=%04h", digits3);
        ticks = 1;
        dones = 0;
        cs = 999;
        for (int i = 0; i < 999 * 4 + 20 && dones == 0; i++) begin
            cyc(1);
            if (tick3) begin
                ticks++;
                cs--;
                check_eq("borrow_step", 32'(digits3), 32'(cs_to_bcd(cs)));
            end
            if (done3) dones++;
        end
        cyc(6);
        if (done3) dones++;
        check_eq("borrow_ticks", 32'(ticks), 32'd1000);
        check_eq("borrow_dones", 32'(dones), 32'd1);
        check_eq("borrow_final", 32'(digits3), 32'h0000);
        check_eq("borrow_stopped", 32'(running3), 32'd0);
        $display("txn borrow chain: ticks=%0d dones=%0d", ticks, dones);

        // Pause/resume on DIV_TERM=9
        do_load(16'h0005);
        do_start();
        cyc(5);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        check_eq("pause_running", 32'(running9), 32'd0);
        cyc(20);
        check_eq("pause_hold", 32'(digits9), 32'h0005);
        do_start();
        check_eq("resume_running", 32'(running9), 32'd1);
        cyc(4);
        check_eq("resume_no_tick", 32'(tick9), 32'd0);
        cyc(1);
        check_eq("resume_tick", 32'(tick9), 32'd1);
        check_eq("resume_digits", 32'(digits9), 32'h0004);
        $display("txn pause/resume: digits=%04h", digits9);

        // Stop while prescaler is 0 (DIV_TERM=3)
        do_load(16'h0005);
        do_start();
        cyc(3);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        check_eq("stop0_no_tick", 32'(tick3), 32'd0);
        check_eq("stop0_digits", 32'(digits3), 32'h0005);
        do_start();
        check_eq("stop0_restart_no_tick", 32'(tick3), 32'd0);
        cyc(1);
        check_eq("stop0_first_tick", 32'(tick3), 32'd1);
        check_eq("stop0_digits_dec", 32'(digits3), 32'h0004);
        $display("txn stop at zero: digits=%04h", digits3);

        // Load coincident with a tick
        do_load(16'h0005);
        do_start();
        cyc(3);
        do_load(16'h0007);
        check_eq("loadtick_no_tick", 32'(tick3), 32'd0);
        check_eq("loadtick_no_done", 32'(done3), 32'd0);
        check_eq("loadtick_digits", 32'(digits3), 32'h0007);
        check_eq("loadtick_idle", 32'(running3), 32'd0);
        $display("txn load on tick: digits=%04h", digits3);

        // Start with 00.00 is ignored
        do_load(16'h0000);
        do_start();
        check_eq("zero_start_idle", 32'(running3), 32'd0);
        cyc(5);
        check_eq("zero_no_tick", 32'(tick3), 32'd0);
        check_eq("zero_no_done", 32'(done3), 32'd0);
        check_eq("zero_digits", 32'(digits3), 32'h0000);
        $display("txn start at zero: running=%0b", running3);

        // load + start same cycle
        preset = 16'h0042;
        load = 1'b1;
        start = 1'b1;
        cyc(1);
        load = 1'b0;
        start = 1'b0;
        check_eq("loadstart_digits", 32'(digits3), 32'h0042);
        check_eq("loadstart_idle", 32'(running3), 32'd0);
        $display("txn load+start: digits=%04h running=%0b", digits3, running3);

        // Sanitizing
        do_load(16'hF7AB);
        check_eq("sanitize", 32'(digits3), 32'h5799);
        $display("txn sanitize: digits=%04h", digits3);

        // preset change without load has no effect
        preset = 16'h1234;
        cyc(2);
        check_eq("preset_no_load", 32'(digits3), 32'h5799);

        // Mid-run reset
        do_load(16'h0042);
        do_start();
        check_eq("midrst_running", 32'(running3), 32'd1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check_eq("midrst_digits", 32'(digits3), 32'h0000);
        check_eq("midrst_running_low", 32'(running3), 32'd0);
        check_eq("midrst_done", 32'(done3), 32'd0);
        cyc(1);
        check_eq("midrst_done_after", 32'(done3), 32'd0);
        $display("txn mid-run reset: digits=%04h running=%0b", digits3, running3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
